// File: rtl/slt_arbiter_if.sv
// Request/response bundle for the two-requester signed-less-than arbiter.
// The master side drives requests and consumes responses; the slave side is the arbiter.
interface slt_arbiter_if;
   logic        req0_valid;
   logic        req1_valid;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        req0_ready;
   logic        req1_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_slt;

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_slt
   );

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_slt
   );
endinterface

// File: rtl/slt_arbiter.sv
// Round-robin arbiter in front of one shared signed-less-than unit.
// One operation is in flight at a time: IDLE -> COMPUTE (COMPUTE_CYCLES) -> RESP.
module slt_arbiter #(
   parameter int unsigned COMPUTE_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   slt_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      RESP    = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(COMPUTE_CYCLES - 1);

   state_t      state_r;
   logic        ptr_r;
   logic [3:0]  cnt_r;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic        id_r;
   logic        rsp_valid_r;
   logic        rsp_id_r;
   logic        rsp_slt_r;
   logic        grant0_s;
   logic        grant1_s;

   // Signed a < b from the subtract flags: sign of a - b corrected by overflow.
   function automatic logic slt_bit(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      logic        carry31;
      logic        overflow;
      sum      = {1'b0, a} + {1'b0, ~b} + 33'd1;
      carry31  = a[31] ^ ~b[31] ^ sum[31];
      overflow = carry31 ^ sum[32];
      return sum[31] ^ overflow;
   endfunction

   // Grant decode: only in IDLE and out of reset; ptr_r names the favoured requester.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (rst_n && (state_r == IDLE)) begin
         if (bus.req0_valid && (!ptr_r || !bus.req1_valid)) begin
            grant0_s = 1'b1;
         end else if (bus.req1_valid) begin
            grant1_s = 1'b1;
         end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   assign bus.req0_ready = grant0_s;
   assign bus.req1_ready = grant1_s;
   assign bus.rsp_valid  = rsp_valid_r;
   assign bus.rsp_id     = rsp_id_r;
   assign bus.rsp_slt    = {31'd0, rsp_slt_r};

   // Operation sequencer: accept, settle for COMPUTE_CYCLES, then hold the result until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         ptr_r       <= 1'b0;
         cnt_r       <= 4'd0;
         a_r         <= 32'd0;
         b_r         <= 32'd0;
         id_r        <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= 1'b0;
         rsp_slt_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant0_s || grant1_s) begin
                  a_r     <= grant1_s ? bus.req1_a : bus.req0_a;
                  b_r     <= grant1_s ? bus.req1_b : bus.req0_b;
                  id_r    <= grant1_s;
                  ptr_r   <= ~grant1_s;
                  cnt_r   <= CNT_LOAD;
                  state_r <= COMPUTE;
               end
            end
            COMPUTE: begin
               if (cnt_r == 4'd0) begin
                  rsp_slt_r   <= slt_bit(a_r, b_r);
                  rsp_id_r    <= id_r;
                  rsp_valid_r <= 1'b1;
                  state_r     <= RESP;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end
endmodule
